nixie_mux_scheduler: RTL
========================

NIXIE_MUX_SCHEDULER -- requirements
Module: nixie_mux_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 200000: cycles a tube is lit per slot (2 ms at 100 MHz); legal range >= 1.
REQ-002 Parameter BLANK_CYCLES, default 10000: dead-time cycles before each slot, all tubes off; legal range >= 1.
REQ-003 Parameter POISON_FRAMES, default 50: full frames per digit step during anti-poison cycling; legal range >= 1.
REQ-004 clk  input  1  100 MHz onboard clock.
REQ-005 rst  input  1  reset; one clock, asynchronous, active-high.
REQ-006 digits  input  24  six BCD digits; tube n in bits [4n+3:4n].
REQ-007 blank_mask  input  6  1 = tube n suppressed (e.g. leading zero).
REQ-008 poison_req  input  1  single-cycle request for an anti-poison cathode sweep.
REQ-009 nixie_enable  output  6  one-hot tube anode enable; never more than one bit high.
REQ-010 nixie_value  output  4  BCD digit for the cathode decoder.
REQ-011 frame_start  output  1  one-cycle pulse at the start of every frame.
REQ-012 poison_busy  output  1  high while a sweep is pending or running.

Function
REQ-013 The FSM SHALL have two states, BLANK and ON, plus a slot index 0..5 and a cycle counter sized to hold max(DWELL_CYCLES, BLANK_CYCLES).
REQ-014 BLANK SHALL last exactly BLANK_CYCLES cycles with nixie_enable = 0, then enter ON.
REQ-015 ON SHALL last exactly DWELL_CYCLES cycles, then enter BLANK with the index incremented, wrapping 5 -> 0.
REQ-016 A frame SHALL be 6*(BLANK_CYCLES+DWELL_CYCLES) cycles; frame_start SHALL pulse in the first cycle of BLANK for index 0.
REQ-017 nixie_value SHALL be loaded only in the first BLANK cycle of a slot (the digit is sampled from digits at that edge) and held through ON; mid-slot digit changes SHALL NOT affect the current slot.
REQ-018 In ON, nixie_enable SHALL be one-hot on the index unless blank_mask[index] = 1 or the sampled digit > 9, in which case it SHALL be 0; slot timing SHALL be unchanged either way.
REQ-019 blank_mask SHALL be sampled together with the digit at slot start.
REQ-020 poison_req while poison_busy = 0 SHALL set a pending flag; poison_busy SHALL rise in the next cycle; poison_req while busy SHALL be ignored.
REQ-021 A pending sweep SHALL start at the next frame_start: steps k = 0..9, each lasting POISON_FRAMES frames, every slot showing value k with blank_mask and digits ignored.
REQ-022 The sweep SHALL end at the frame_start after step 9; normal display SHALL resume in that frame and poison_busy SHALL fall in the same cycle.
REQ-023 A poison_req coinciding with the frame_start SHALL start the sweep at the following frame_start, not the current one.

Reset
REQ-024 On rst, all outputs SHALL go to 0 immediately: nixie_enable, nixie_value, frame_start and poison_busy; the pending flag SHALL clear.
REQ-025 While rst is high, the state SHALL be BLANK, the index 0, the counter 0 and the sweep step 0.
REQ-026 Reset asserted mid-slot or mid-sweep SHALL abort the slot or sweep.
REQ-027 The first edge after reset release SHALL begin BLANK for index 0; frame_start SHALL pulse on that edge.

Configuration
REQ-028 Macro NIXIE_ANTIPOISON_EN SHALL control the anti-poison sweep.
REQ-029 When NIXIE_ANTIPOISON_EN is defined, REQ-020 to REQ-023 SHALL apply.
REQ-030 When NIXIE_ANTIPOISON_EN is undefined, poison_req SHALL be ignored, poison_busy SHALL be tied to 0, and no sweep logic SHALL be built.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, POISON_FRAMES=1, giving a frame of 36 cycles)
REQ-031 Release reset with digits=24'h123456 and mask 0 -> frame_start pulses at cycle 0; cycles 2-5 nixie_enable=6'b000001 and value=6; cycles 8-11 enable=6'b000010 and value=5; and so on through tube 5 (value 1); cycle 36 frame_start pulses again.
REQ-032 blank_mask=6'b100000 -> cycles 32-35 nixie_enable=0 with value=1; all other slots and timing unchanged.
REQ-033 digits[11:8]=4'hA -> tube 2 slot (cycles 14-17) nixie_enable=0; nixie_enable is never non-one-hot anywhere in the frame.
REQ-034 Change digits from 24'h123456 to 24'h000000 at cycle 3 -> value stays 6 through cycle 5; tube 1 slot shows 0.
REQ-035 poison_req at cycle 10 (ANTIPOISON_EN defined) -> poison_busy=1 from cycle 11; frames starting at 36 through 360 show 0..9 on all tubes in turn; poison_busy=0 and normal digits resume at cycle 396; a second poison_req at cycle 100 has no effect.
REQ-036 Assert rst at cycle 3 while ON -> nixie_enable=0 before the next clk edge; after release, timing restarts per REQ-027.

Source files
------------

// File: rtl/nixie_mux_scheduler.sv
// Six-tube nixie multiplexer: BLANK dead-time then ON dwell per slot, one slot per tube.
// Optional anti-poison cathode sweep built only when NIXIE_ANTIPOISON_EN is defined.
module nixie_mux_scheduler #(
  parameter int DWELL_CYCLES  = 200000,
  parameter int BLANK_CYCLES  = 10000,
  parameter int POISON_FRAMES = 50
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [23:0] digits_i,
  input  logic [5:0]  blank_mask_i,
  input  logic        poison_req_i,
  output logic [5:0]  nixie_enable_o,
  output logic [3:0]  nixie_value_o,
  output logic        frame_start_o,
  output logic        poison_busy_o
);

  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q;
  logic               sup_q;
  logic               slot_start, frame_d;
  logic               sweep_d;
  logic [3:0]         step_d;
  logic               busy_d;
  logic [3:0]         dig_sel;
  logic               mask_sel;

  // run_q low means the next edge is the very first cycle of a frame.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q - CNT_W'(1);
    slot_start = 1'b0;
    if (!run_q) begin
      state_d    = S_BLANK;
      idx_d      = 3'd0;
      cnt_d      = CNT_W'(BLANK_CYCLES - 1);
      slot_start = 1'b1;
    end else if (cnt_q == '0) begin
      if (state_q == S_BLANK) begin
        state_d = S_ON;
        cnt_d   = CNT_W'(DWELL_CYCLES - 1);
      end else begin
        state_d    = S_BLANK;
        idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        cnt_d      = CNT_W'(BLANK_CYCLES - 1);
        slot_start = 1'b1;
      end
    end
    frame_d  = slot_start && (idx_d == 3'd0);
    dig_sel  = digits_i[{idx_d, 2'b00} +: 4];
    mask_sel = blank_mask_i[idx_d];
  end

`ifdef NIXIE_ANTIPOISON_EN
  localparam int FW = $clog2(POISON_FRAMES + 1);

  logic          pend_q, pend_d;
  logic          sweep_q;
  logic [3:0]    step_q;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // A request accepted at a frame-start edge already counts for that frame;
  // a request seen while frame_start is high arrives one edge too late.
  always_comb begin
    sweep_d = sweep_q;
    step_d  = step_q;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q | (poison_req_i & ~poison_busy_o);
    if (frame_d) begin
      if (sweep_q) begin
        if (fcnt_q == '0) begin
          if (step_q == 4'd9) begin
            sweep_d = 1'b0;
          end else begin
            step_d = step_q + 4'd1;
            fcnt_d = FW'(POISON_FRAMES - 1);
          end
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end else if (pend_d) begin
        sweep_d = 1'b1;
        pend_d  = 1'b0;
        step_d  = 4'd0;
        fcnt_d  = FW'(POISON_FRAMES - 1);
      end
    end
    busy_d = pend_d | sweep_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      sweep_q <= 1'b0;
      step_q  <= 4'd0;
      fcnt_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      sweep_q <= sweep_d;
      step_q  <= step_d;
      fcnt_q  <= fcnt_d;
    end
  end
`else
  logic poison_req_unused;
  assign poison_req_unused = poison_req_i;
  assign sweep_d = 1'b0;
  assign step_d  = 4'd0;
  assign busy_d  = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_BLANK;
      idx_q          <= 3'd0;
      cnt_q          <= '0;
      run_q          <= 1'b0;
      sup_q          <= 1'b0;
      nixie_enable_o <= 6'd0;
      nixie_value_o  <= 4'd0;
      frame_start_o  <= 1'b0;
      poison_busy_o  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      run_q         <= 1'b1;
      frame_start_o <= frame_d;
      poison_busy_o <= busy_d;
      // Digit and suppression are latched once per slot and held through ON.
      if (slot_start) begin
        if (sweep_d) begin
          nixie_value_o <= step_d;
          sup_q         <= 1'b0;
        end else begin
          nixie_value_o <= dig_sel;
          sup_q         <= mask_sel | (dig_sel > 4'd9);
        end
      end
      if (state_d == S_ON && !sup_q) nixie_enable_o <= 6'b000001 << idx_d;
      else                           nixie_enable_o <= 6'd0;
    end
  end

endmodule
